de0_training_unit: RTL and testbench
====================================

Name:
de0_training_unit

Overview:
- Small board-training datapath for the DE0 kit.
- Selects and combines two 4-bit inputs under a 2-bit opcode and registers the result onto a 4-bit LED/7-seg bus.
- An independent free-running divider drives a blink LED.
- Sits directly under the board top level, between switch/key inputs and LED outputs.

Parameters:
- D_SIZE, default 2: blink divider exponent. `blink` toggles once every 2^D_SIZE clocks. Legal range 1..26.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- n_rst, input, 1: reset. Synchronous and active-high: a 1 sampled on a rising clk edge resets the block. The port keeps the codebase name despite the n_ prefix.
- din_0, input, 4: operand A.
- din_1, input, 4: operand B.
- sel, input, 2: operation select.
- dout, output, 4: registered result.
- blink, output, 1: divided-clock LED drive.

Behaviour:
- Reset (n_rst=1 at a clk edge):
  - dout <= 4'h0, blink <= 0, blink counter <= 0.
  - Reset has priority over every other update.
  - Asserting reset mid-operation discards any pending result on that edge.
- Result path: combinational function f(sel, din_0, din_1), registered into dout on every non-reset edge. Latency is 1 clock: inputs present before edge k appear on dout after edge k.
  - sel=0: f = din_0 (pass A).
  - sel=1: f = din_1 (pass B).
  - sel=2: f = (din_0 + din_1) mod 16. Compute a 5-bit sum internally and drop the carry.
  - sel=3: f = (din_0 * din_1) mod 16. Compute an 8-bit product internally and keep bits [3:0].
- Inputs are sampled only at clock edges. No handshake; a new result is produced every cycle.
- sel changes take effect on the next edge with no extra pipeline bubble.
- Blink path:
  - D_SIZE-bit up-counter increments every non-reset clock.
  - When the counter equals 2^D_SIZE-1: the counter wraps to 0 and blink inverts on the same edge.
  - Blink period is 2^(D_SIZE+1) clocks, 50% duty.
  - With D_SIZE=2, after reset release the first blink rise is at the 4th edge, the fall at the 8th edge, and so on.
- Counter and datapath are independent; sel/din activity never affects blink.
- All outputs come directly from flops; no combinational path from inputs to outputs.

Optional Feature:
- Macro DE0_TRAINING_SAT_EN.
- When defined:
  - sel=2 and sel=3 saturate: if the full-width sum or product exceeds 15, f = 4'hF.
  - Otherwise f is the exact value.
- When undefined: modulo-16 wrap as specified above.
- sel=0 and sel=1 are unaffected in both builds.

Test Plan:
- Reset: hold n_rst=1 for 2 edges with random din/sel -> dout=0, blink=0. Release -> blink rises after exactly 4 edges, falls 4 edges later, repeating (D_SIZE=2).
- Pass A: sel=0, din_0 stepping 0..15 each cycle, din_1=0 -> dout equals the previous cycle's din_0. din_1 changes have no effect.
- Pass B: sel=1, din_1 stepping 0..15 -> dout follows din_1 with 1-cycle latency. e.g. din_1=9 -> dout=9 next cycle.
- Add sweep: sel=2, all 256 (din_0, din_1) pairs, one per cycle -> dout=(a+b) mod 16, e.g. 7+5=12, 9+8=1, 15+15=14. With DE0_TRAINING_SAT_EN: 9+8=15, 15+15=15.
- Multiply sweep: sel=3, all 256 pairs -> dout=(a*b) mod 16, e.g. 3*5=15, 4*4=0, 15*15=1, 0*x=0. With DE0_TRAINING_SAT_EN: 4*4=15, 3*5=15, 2*7=14.
- Reset mid-sweep: assert n_rst=1 for 1 edge during the sel=2 sweep -> dout=0 and blink=0 on that edge. Counter restarts, so the next blink rise is 4 edges after release.

Source files
------------

// File: rtl/de0_training_unit.sv
// rtl/de0_training_unit.sv - DE0 training datapath: opcode-selected A/B combine into registered dout, plus blink divider
// Optional build macro DE0_TRAINING_SAT_EN: sel=2/3 saturate at 4'hF instead of wrapping modulo 16.
module de0_training_unit #(
    parameter int D_SIZE = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] din_0,
    input  logic [3:0] din_1,
    input  logic [1:0] sel,
    output logic [3:0] dout,
    output logic       blink
);

    logic [3:0]        dout_q, dout_d;
    logic              blink_q, blink_d;
    logic [D_SIZE-1:0] cnt_q, cnt_d;

    logic [4:0] sum;
    logic [7:0] prod;
    logic [3:0] add_res;
    logic [3:0] mul_res;

    // Full-width intermediates so the saturating build can see overflow.
    always_comb begin
        sum  = {1'b0, din_0} + {1'b0, din_1};
        prod = {4'b0000, din_0} * {4'b0000, din_1};
`ifdef DE0_TRAINING_SAT_EN
        add_res = (sum > 5'd15) ? 4'hF : sum[3:0];
        mul_res = (prod > 8'd15) ? 4'hF : prod[3:0];
`else
        add_res = sum[3:0];
        mul_res = prod[3:0];
`endif
    end

    always_comb begin
        dout_d = dout_q;
        case (sel)
            2'd0:    dout_d = din_0;
            2'd1:    dout_d = din_1;
            2'd2:    dout_d = add_res;
            default: dout_d = mul_res;
        endcase
    end

    // Blink toggles on the same edge the divider wraps back to zero.
    always_comb begin
        cnt_d   = cnt_q + {{(D_SIZE-1){1'b0}}, 1'b1};
        blink_d = blink_q;
        if (cnt_q == {D_SIZE{1'b1}}) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            dout_q  <= 4'h0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            dout_q  <= dout_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout  = dout_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_de0_training_unit.sv
// tb/tb_de0_training_unit.sv - scoreboard bench for de0_training_unit with randomized stimulus
module tb_de0_training_unit;

    localparam int D_SIZE = 2;

    logic       clk;
    logic       n_rst;
    logic [3:0] din_0;
    logic [3:0] din_1;
    logic [1:0] sel;
    logic [3:0] dout;
    logic       blink;

    typedef struct {
        int  dout;
        int  blink;
        int  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   passes;
    int   edges_since_rst;
    int   step;

    de0_training_unit #(.D_SIZE(D_SIZE)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .din_0 (din_0),
        .din_1 (din_1),
        .sel   (sel),
        .dout  (dout),
        .blink (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_f(input int s, input int a, input int b);
        int r;
        case (s)
            0: r = a;
            1: r = b;
            2: r = a + b;
            default: r = a * b;
        endcase
        if (s >= 2) begin
`ifdef DE0_TRAINING_SAT_EN
            if (r > 15) r = 15;
`else
            r = r % 16;
`endif
        end
        return r;
    endfunction

    // Apply one cycle of inputs, record what the following edge must produce.
    task automatic drive(input int rst, input int s, input int a, input int b);
        exp_t e;
        n_rst = rst[0];
        sel   = s[1:0];
        din_0 = a[3:0];
        din_1 = b[3:0];
        if (rst != 0) begin
            edges_since_rst = 0;
            e.dout = 0;
        end else begin
            edges_since_rst = edges_since_rst + 1;
            e.dout = model_f(s, a, b);
        end
        e.blink = (edges_since_rst / (1 << D_SIZE)) % 2;
        e.tag   = step;
        step    = step + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (int'(dout) == e.dout) passes = passes + 1;
                else $display("FAIL dout step %0d: got %0d expected %0d", e.tag, dout, e.dout);
                checks = checks + 1;
                if (int'(blink) == e.blink) passes = passes + 1;
                else $display("FAIL blink step %0d: got %0d expected %0d", e.tag, blink, e.blink);
            end
        end
    end

    initial begin : stimulus
        checks = 0;
        passes = 0;
        edges_since_rst = 0;
        step = 0;
        n_rst = 1'b1;
        sel = 2'd0;
        din_0 = 4'd0;
        din_1 = 4'd0;

        for (int i = 0; i < 2; i++)
            drive(1, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));

        for (int i = 0; i < 16; i++)
            drive(0, 0, i, $urandom_range(0, 15));

        for (int i = 0; i < 16; i++)
            drive(0, 1, $urandom_range(0, 15), i);

        for (int i = 0; i < 256; i++)
            drive((i == 100) ? 1 : 0, 2, i / 16, i % 16);

        for (int i = 0; i < 256; i++)
            drive(0, 3, i / 16, i % 16);

        for (int i = 0; i < 200; i++)
            drive(($urandom_range(0, 24) == 0) ? 1 : 0, $urandom_range(0, 3),
                  $urandom_range(0, 15), $urandom_range(0, 15));

        repeat (3) @(posedge clk);
        #3;
        checks = checks + 1;
        if (exp_q.size() == 0) passes = passes + 1;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
